// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - grid snake game core: move ticks, steering, ring-buffer body, food, render
// Body lives in a ring buffer for tail lookup; an occupancy bitmap answers collision and render queries.
module snake_engine #(
   parameter int          GRID_W    = 32,
   parameter int          GRID_H    = 24,
   parameter int          CELL      = 20,
   parameter int          MAX_LEN   = 64,
   parameter int          TICK_DIV  = 10_000_000,
   parameter int          WRAP      = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        left,
   input  logic        right,
   input  logic        up,
   input  logic        down,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   output logic [11:0] color,
   output logic [7:0]  length,
   output logic [7:0]  score,
   output logic        game_over
);

   localparam int NCELL = GRID_W * GRID_H;
   localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
   localparam int PW    = $clog2(MAX_LEN);
   localparam int CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [7:0]    W8        = 8'(GRID_W);
   localparam logic [7:0]    H8        = 8'(GRID_H);
   localparam logic [9:0]    W10       = 10'(GRID_W);
   localparam logic [9:0]    H10       = 10'(GRID_H);
   localparam logic [9:0]    CELL10    = 10'(CELL);
   localparam logic [7:0]    MAX8      = 8'(MAX_LEN);
   localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_LEN - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
   localparam logic [7:0]    START_X   = 8'(GRID_W / 2);
   localparam logic [7:0]    START_Y   = 8'(GRID_H / 2);
   localparam logic [7:0]    FOOD_X0   = 8'(GRID_W / 4);
   localparam logic [7:0]    FOOD_Y0   = 8'(GRID_H / 4);
   localparam logic [IW-1:0] START_IDX = IW'((GRID_H / 2) * GRID_W + GRID_W / 2);

   localparam logic [1:0] DIR_LEFT  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   typedef enum logic [1:0] {S_RUN, S_STEP, S_PLACE, S_DEAD} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             pending;
   logic [1:0]       dir;
   logic [1:0]       next_dir;
   logic [7:0]       body_x [MAX_LEN];
   logic [7:0]       body_y [MAX_LEN];
   logic [PW-1:0]    head_ptr;
   logic [PW-1:0]    tail_ptr;
   logic [7:0]       head_x, head_y;
   logic [7:0]       food_x, food_y;
   logic [NCELL-1:0] occ;
   logic [15:0]      lfsr;

   function automatic logic [IW-1:0] cell_idx(input logic [9:0] x, input logic [9:0] y);
      return IW'(32'(y) * 32'(GRID_W) + 32'(x));
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   logic       tick;
   logic       req_valid;
   logic [1:0] req_dir;
   logic [1:0] ref_dir;
   logic       accept_req;

   assign tick = (state != S_DEAD) && (cnt == CNT_LAST);

   always_comb begin
      req_valid = 1'b1;
      req_dir   = DIR_RIGHT;
      if (left)       req_dir = DIR_LEFT;
      else if (right) req_dir = DIR_RIGHT;
      else if (up)    req_dir = DIR_UP;
      else if (down)  req_dir = DIR_DOWN;
      else            req_valid = 1'b0;
   end

   // During STEP the latched direction is being committed, so reversal is judged against it.
   assign ref_dir    = (state == S_STEP) ? next_dir : dir;
   assign accept_req = req_valid && (req_dir != (ref_dir ^ 2'b01));

   logic [7:0]    new_x, new_y;
   logic          off_grid;

   always_comb begin
      new_x    = head_x;
      new_y    = head_y;
      off_grid = 1'b0;
      case (next_dir)
         DIR_LEFT: begin
            if (head_x == 8'd0) begin new_x = W8 - 8'd1; off_grid = 1'b1; end
            else new_x = head_x - 8'd1;
         end
         DIR_RIGHT: begin
            if (head_x == W8 - 8'd1) begin new_x = 8'd0; off_grid = 1'b1; end
            else new_x = head_x + 8'd1;
         end
         DIR_UP: begin
            if (head_y == 8'd0) begin new_y = H8 - 8'd1; off_grid = 1'b1; end
            else new_y = head_y - 8'd1;
         end
         default: begin
            if (head_y == H8 - 8'd1) begin new_y = 8'd0; off_grid = 1'b1; end
            else new_y = head_y + 8'd1;
         end
      endcase
   end

   logic [IW-1:0] new_idx, tail_idx;
   logic [PW-1:0] head_next;
   logic [7:0]    tail_x, tail_y;
   logic          at_food, grow, hits_tail, collide;

   assign head_next = ptr_inc(head_ptr);
   assign tail_x    = body_x[tail_ptr];
   assign tail_y    = body_y[tail_ptr];
   assign new_idx   = cell_idx({2'b00, new_x}, {2'b00, new_y});
   assign tail_idx  = cell_idx({2'b00, tail_x}, {2'b00, tail_y});
   assign at_food   = (new_x == food_x) && (new_y == food_y);
   assign grow      = at_food && (length < MAX8);
   assign hits_tail = (new_x == tail_x) && (new_y == tail_y);
   assign collide   = ((WRAP == 0) && off_grid) || (occ[new_idx] && !(hits_tail && !grow));

   logic [7:0]  cand_x, cand_y;
   logic        cand_ok;
   logic [15:0] lfsr_next;

   assign cand_x    = lfsr[7:0];
   assign cand_y    = lfsr[15:8];
   assign cand_ok   = (cand_x < W8) && (cand_y < H8) &&
                      !occ[cell_idx({2'b00, cand_x}, {2'b00, cand_y})];
   assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

   logic [9:0]    cell_x, cell_y;
   logic [IW-1:0] pix_idx;
   logic          pix_in_grid;
   logic [11:0]   pix_color;

   assign cell_x      = pix_x / CELL10;
   assign cell_y      = pix_y / CELL10;
   assign pix_in_grid = (cell_x < W10) && (cell_y < H10);
   assign pix_idx     = cell_idx(cell_x, cell_y);

   always_comb begin
      pix_color = 12'h000;
      if (!pix_in_grid)                                              pix_color = 12'h444;
      else if (state == S_DEAD && occ[pix_idx])                      pix_color = 12'hf80;
      else if (cell_x == {2'b00, head_x} && cell_y == {2'b00, head_y}) pix_color = 12'h0f0;
      else if (occ[pix_idx])                                         pix_color = 12'h0a0;
      else if (cell_x == {2'b00, food_x} && cell_y == {2'b00, food_y}) pix_color = 12'hf00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_RUN;
         cnt            <= '0;
         pending        <= 1'b0;
         dir            <= DIR_RIGHT;
         next_dir       <= DIR_RIGHT;
         head_ptr       <= '0;
         tail_ptr       <= '0;
         head_x         <= START_X;
         head_y         <= START_Y;
         body_x[0]      <= START_X;
         body_y[0]      <= START_Y;
         occ            <= '0;
         occ[START_IDX] <= 1'b1;
         food_x         <= FOOD_X0;
         food_y         <= FOOD_Y0;
         lfsr           <= LFSR_SEED;
         length         <= 8'd1;
         score          <= 8'd0;
         game_over      <= 1'b0;
         color          <= 12'h000;
      end else begin
         color <= pix_color;
         if (state != S_DEAD) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         if (accept_req) next_dir <= req_dir;

         case (state)
            S_RUN: begin
               if (tick || pending) begin
                  state   <= S_STEP;
                  pending <= 1'b0;
               end
            end
            S_STEP: begin
               pending <= pending | tick;
               dir     <= next_dir;
               if (collide) begin
                  state     <= S_DEAD;
                  game_over <= 1'b1;
               end else begin
                  head_ptr          <= head_next;
                  body_x[head_next] <= new_x;
                  body_y[head_next] <= new_y;
                  head_x            <= new_x;
                  head_y            <= new_y;
                  // Tail clear precedes head set so a head entering the vacated tail cell stays marked.
                  if (!grow) begin
                     occ[tail_idx] <= 1'b0;
                     tail_ptr      <= ptr_inc(tail_ptr);
                  end else begin
                     length <= length + 8'd1;
                  end
                  occ[new_idx] <= 1'b1;
                  if (at_food) begin
                     if (score != 8'hff) score <= score + 8'd1;
                     state <= S_PLACE;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_PLACE: begin
               pending <= pending | tick;
               lfsr    <= lfsr_next;
               if (cand_ok) begin
                  food_x <= cand_x;
                  food_y <= cand_y;
                  state  <= S_RUN;
               end
            end
            S_DEAD: ;
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - randomized bench for snake_engine (wrapping and walled instances)
// The reference keeps the snake as a head-first coordinate list and evaluates each clock from the game rules.
module tb_snake_engine;

   localparam int GW   = 8;
   localparam int GH   = 8;
   localparam int CELL = 4;
   localparam int ML   = 4;
   localparam int TD   = 4;
   localparam int SEED = 'hACE1;

   localparam int RUN = 0, STEP = 1, PLACE = 2, DEAD = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        left, right, up, down;
   logic [9:0]  pix_x, pix_y;
   logic [11:0] color_w, color_nw;
   logic [7:0]  length_w, length_nw, score_w, score_nw;
   logic        game_over_w, game_over_nw;

   snake_engine #(.GRID_W(GW), .GRID_H(GH), .CELL(CELL), .MAX_LEN(ML), .TICK_DIV(TD),
                  .WRAP(1), .LFSR_SEED(16'hACE1)) u_wrap (
      .clk(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
      .pix_x(pix_x), .pix_y(pix_y), .color(color_w), .length(length_w),
      .score(score_w), .game_over(game_over_w));

   snake_engine #(.GRID_W(GW), .GRID_H(GH), .CELL(CELL), .MAX_LEN(ML), .TICK_DIV(TD),
                  .WRAP(0), .LFSR_SEED(16'hACE1)) u_nowrap (
      .clk(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
      .pix_x(pix_x), .pix_y(pix_y), .color(color_nw), .length(length_nw),
      .score(score_nw), .game_over(game_over_nw));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int ph[2], cnt[2], pend[2], dir[2], ndir[2], slen[2];
   int fx[2], fy[2], lf[2], sc[2], go[2], col[2];
   int sx[2][ML];
   int sy[2][ML];

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit occupied(input int m, input int x, input int y);
      for (int i = 0; i < slen[m]; i++)
         if (sx[m][i] == x && sy[m][i] == y) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int lfsr_step(input int l);
      int b;
      b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      return (l >> 1) | (b << 15);
   endfunction

   // One clock edge of the game for instance m (0: wrapping edges, 1: walled edges).
   task automatic model_cycle(input int m, input bit rst, input int req, input int px, input int py);
      int tick, refd, nx, ny, cx, cy, c, x, y, newlen;
      bit oor, grow, hit;
      if (rst) begin
         ph[m] = RUN; cnt[m] = 0; pend[m] = 0; dir[m] = 1; ndir[m] = 1;
         slen[m] = 1; sx[m][0] = GW / 2; sy[m][0] = GH / 2;
         fx[m] = GW / 4; fy[m] = GH / 4; lf[m] = SEED; sc[m] = 0; go[m] = 0; col[m] = 0;
         return;
      end
      cx = px / CELL;
      cy = py / CELL;
      if (cx >= GW || cy >= GH)                        c = 'h444;
      else if (ph[m] == DEAD && occupied(m, cx, cy))   c = 'hf80;
      else if (cx == sx[m][0] && cy == sy[m][0])       c = 'h0f0;
      else if (occupied(m, cx, cy))                    c = 'h0a0;
      else if (cx == fx[m] && cy == fy[m])             c = 'hf00;
      else                                             c = 'h000;
      col[m] = c;

      tick = (ph[m] != DEAD && cnt[m] == TD - 1);
      refd = (ph[m] == STEP) ? ndir[m] : dir[m];
      if (ph[m] != DEAD) cnt[m] = (cnt[m] + 1) % TD;

      case (ph[m])
         RUN: if (tick || pend[m]) begin ph[m] = STEP; pend[m] = 0; end
         STEP: begin
            if (tick) pend[m] = 1;
            dir[m] = ndir[m];
            nx = sx[m][0] + (ndir[m] == 0 ? -1 : ndir[m] == 1 ? 1 : 0);
            ny = sy[m][0] + (ndir[m] == 2 ? -1 : ndir[m] == 3 ? 1 : 0);
            oor = (nx < 0 || nx >= GW || ny < 0 || ny >= GH);
            nx = (nx + GW) % GW;
            ny = (ny + GH) % GH;
            grow = (nx == fx[m] && ny == fy[m]) && slen[m] < ML;
            hit = occupied(m, nx, ny) &&
                  !(!grow && nx == sx[m][slen[m]-1] && ny == sy[m][slen[m]-1]);
            if ((oor && m == 1) || hit) begin
               ph[m] = DEAD;
               go[m] = 1;
            end else begin
               newlen = grow ? slen[m] + 1 : slen[m];
               for (int i = newlen - 1; i > 0; i--) begin
                  sx[m][i] = sx[m][i-1];
                  sy[m][i] = sy[m][i-1];
               end
               sx[m][0] = nx;
               sy[m][0] = ny;
               slen[m] = newlen;
               if (nx == fx[m] && ny == fy[m]) begin
                  if (sc[m] < 255) sc[m]++;
                  ph[m] = PLACE;
               end else begin
                  ph[m] = RUN;
               end
            end
         end
         PLACE: begin
            if (tick) pend[m] = 1;
            x = lf[m] & 255;
            y = (lf[m] >> 8) & 255;
            lf[m] = lfsr_step(lf[m]);
            if (x < GW && y < GH && !occupied(m, x, y)) begin
               fx[m] = x; fy[m] = y; ph[m] = RUN;
            end
         end
         default: ;
      endcase

      if (req >= 0 && req != (refd ^ 1)) ndir[m] = req;
   endtask

   initial begin
      int req, r, dead0, dead1;
      reset = 1'b1;
      {left, right, up, down} = 4'b0000;
      pix_x = '0;
      pix_y = '0;
      dead0 = 0;
      dead1 = 0;
      for (int cyc = 0; cyc < 30000 && n_errors < 40; cyc++) begin
         req = left ? 0 : right ? 1 : up ? 2 : down ? 3 : -1;
         model_cycle(0, reset, req, int'(pix_x), int'(pix_y));
         model_cycle(1, reset, req, int'(pix_x), int'(pix_y));
         @(posedge clk);
         @(negedge clk);
         check_eq("wrap_color",      int'(color_w),      col[0]);
         check_eq("wrap_length",     int'(length_w),     slen[0]);
         check_eq("wrap_score",      int'(score_w),      sc[0]);
         check_eq("wrap_game_over",  int'(game_over_w),  go[0]);
         check_eq("wall_color",      int'(color_nw),     col[1]);
         check_eq("wall_length",     int'(length_nw),    slen[1]);
         check_eq("wall_score",      int'(score_nw),     sc[1]);
         check_eq("wall_game_over",  int'(game_over_nw), go[1]);

         dead0 = go[0] ? dead0 + 1 : 0;
         dead1 = go[1] ? dead1 + 1 : 0;
         reset = (cyc < 2) || (dead0 > 30) || (dead1 > 400) ||
                 ($urandom_range(0, 2999) == 0) ||
                 (ph[0] == PLACE && $urandom_range(0, 299) == 0);

         {left, right, up, down} = 4'b0000;
         if (cyc >= 40 && $urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 4) < 3) begin
               if (fx[0] > sx[0][0])      right = 1'b1;
               else if (fx[0] < sx[0][0]) left  = 1'b1;
               else if (fy[0] > sy[0][0]) down  = 1'b1;
               else if (fy[0] < sy[0][0]) up    = 1'b1;
            end else begin
               {left, right, up, down} = 4'($urandom_range(1, 15));
            end
         end

         r = $urandom_range(0, 7);
         if (r < 2) begin
            pix_x = 10'(sx[0][0] * CELL + $urandom_range(0, CELL - 1));
            pix_y = 10'(sy[0][0] * CELL + $urandom_range(0, CELL - 1));
         end else if (r == 2) begin
            pix_x = 10'(fx[0] * CELL + $urandom_range(0, CELL - 1));
            pix_y = 10'(fy[0] * CELL + $urandom_range(0, CELL - 1));
         end else if (r == 3) begin
            pix_x = 10'($urandom_range(0, 1023));
            pix_y = 10'($urandom_range(0, 1023));
         end else begin
            pix_x = 10'($urandom_range(0, GW * CELL + 7));
            pix_y = 10'($urandom_range(0, GH * CELL + 7));
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
